// File: rtl/fft_mdc_pkg.sv
// -----------------------------------------------------------------------------
// fft_mdc_pkg
//  Shared types and constants for the MDC FFT pipeline stages.
//  - sample_t       : signed complex sample at the default component width
//  - SEL_STRAIGHT / SEL_CROSS : 2x2 commutator switch positions
//  - MODE_SWITCH / MODE_BYPASS: per-frame operating mode of a commutator
//  - SHREG_MAX_DELAY: longest delay built as a plain shift register; longer
//                     delays use a ring buffer
// -----------------------------------------------------------------------------
package fft_mdc_pkg;

  localparam int SAMPLE_W = 9;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } sample_t;

  localparam logic SEL_STRAIGHT = 1'b0;
  localparam logic SEL_CROSS    = 1'b1;

  localparam logic MODE_SWITCH  = 1'b0;
  localparam logic MODE_BYPASS  = 1'b1;

  localparam int SHREG_MAX_DELAY = 8;

endpackage

// File: rtl/mdc_delay_line.sv
// -----------------------------------------------------------------------------
// mdc_delay_line
//  Complex delay of DELAY enabled samples. The output is combinational from
//  the stored contents and always shows the sample written DELAY enables ago,
//  so a caller reading it in the same cycle it writes gets x[n-DELAY].
//  Short delays are a shift register; longer ones are a ring buffer with a
//  single read/write pointer (read-before-write on the same slot).
// Ports
//  clk          in   clock
//  i_clr        in   synchronous clear of contents and pointer
//  i_en         in   advance by one sample
//  i_re/i_im    in   WIDTH  sample written on i_en
//  o_re/o_im    out  WIDTH  sample written DELAY enables ago
// -----------------------------------------------------------------------------
module mdc_delay_line
  import fft_mdc_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DELAY = 8
) (
  input  logic                    clk,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [WIDTH-1:0] i_re,
  input  logic signed [WIDTH-1:0] i_im,
  output logic signed [WIDTH-1:0] o_re,
  output logic signed [WIDTH-1:0] o_im
);

  localparam int SW = 2 * WIDTH;

  generate
    if (DELAY <= SHREG_MAX_DELAY) begin : g_shreg
      logic [SW-1:0] r_tap [DELAY];

      always_ff @(posedge clk) begin
        if (i_clr) begin
          for (int i = 0; i < DELAY; i++) r_tap[i] <= '0;
        end else if (i_en) begin
          r_tap[0] <= {i_re, i_im};
          for (int i = 1; i < DELAY; i++) r_tap[i] <= r_tap[i-1];
        end
      end

      assign o_re = r_tap[DELAY-1][SW-1:WIDTH];
      assign o_im = r_tap[DELAY-1][WIDTH-1:0];
    end else begin : g_ring
      localparam int PW = $clog2(DELAY);
      logic [SW-1:0] r_mem [DELAY];
      logic [PW-1:0] r_ptr;

      // DELAY is a power of two, so the pointer wraps on its own.
      always_ff @(posedge clk) begin
        if (i_clr) begin
          for (int i = 0; i < DELAY; i++) r_mem[i] <= '0;
          r_ptr <= '0;
        end else if (i_en) begin
          r_mem[r_ptr] <= {i_re, i_im};
          r_ptr        <= r_ptr + PW'(1);
        end
      end

      assign o_re = r_mem[r_ptr][SW-1:WIDTH];
      assign o_im = r_mem[r_ptr][WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/mdc_delay_commutator.sv
// -----------------------------------------------------------------------------
// mdc_delay_commutator
//  Delay-commutator stage between MDC FFT butterflies: the upper lane is
//  pre-delayed by DELAY samples, a 2x2 switch crosses the lanes for the second
//  half of every 2*DELAY sample period, and the lower lane is post-delayed by
//  DELAY samples. Bypass mode (latched at start of frame) keeps the switch
//  straight so both lanes are just delayed by DELAY. Pure data movement.
// Ports
//  clk, rst                   clock, synchronous active-high reset
//  in_valid                   input pair valid; all state advances only then
//  in_sof                     start of frame (qualified by in_valid)
//  mode                       0 switch, 1 bypass; taken only with in_sof
//  inUI_re/im, inLI_re/im     upper / lower lane inputs
//  out_valid, out_sof         output pair valid, first valid pair of a frame
//  Up_out_re/im, Low_out_re/im upper / lower lane outputs (hold when idle)
//  misalign_err               one-cycle pulse: sof seen with phase counter != 0
// -----------------------------------------------------------------------------
module mdc_delay_commutator
  import fft_mdc_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DELAY = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] inUI_re,
  input  logic signed [WIDTH-1:0] inUI_im,
  input  logic signed [WIDTH-1:0] inLI_re,
  input  logic signed [WIDTH-1:0] inLI_im,
  output logic                    out_valid,
  output logic                    out_sof,
  output logic signed [WIDTH-1:0] Up_out_re,
  output logic signed [WIDTH-1:0] Up_out_im,
  output logic signed [WIDTH-1:0] Low_out_re,
  output logic signed [WIDTH-1:0] Low_out_im,
  output logic                    misalign_err
);

  localparam int            CW  = $clog2(2 * DELAY);
  localparam logic [CW-1:0] DLY = CW'(DELAY);

  // Control state
  logic [CW-1:0] r_cnt;
  logic          r_primed;
  logic          r_mode_q;
  logic          r_sof_pend;

  // Output registers
  logic                    r_vld_p1;
  logic                    r_sof_p1;
  logic                    r_err_p1;
  logic signed [WIDTH-1:0] r_up_re_p1;
  logic signed [WIDTH-1:0] r_up_im_p1;
  logic signed [WIDTH-1:0] r_low_re_p1;
  logic signed [WIDTH-1:0] r_low_im_p1;

  logic          w_sof;
  logic          w_misalign;
  logic [CW-1:0] w_cnt_eff;
  logic          w_primed_eff;
  logic          w_mode_eff;
  logic          w_second_half;
  logic          w_sel;
  logic          w_out_vld;
  logic          w_out_sof;

  logic signed [WIDTH-1:0] w_ud_re, w_ud_im;
  logic signed [WIDTH-1:0] w_x_re,  w_x_im;
  logic signed [WIDTH-1:0] w_y_re,  w_y_im;
  logic signed [WIDTH-1:0] w_ly_re, w_ly_im;

  // The sample carrying sof already belongs to the new frame: its phase is 0
  // and its mode is the one presented with it. A misaligned sof restarts
  // priming; an aligned one lets the stream continue untouched.
  always_comb begin
    w_sof         = in_valid & in_sof;
    w_misalign    = w_sof & (r_cnt != '0);
    w_cnt_eff     = w_sof ? '0 : r_cnt;
    w_primed_eff  = r_primed & ~w_misalign;
    w_mode_eff    = w_sof ? mode : r_mode_q;
    w_second_half = (w_cnt_eff >= DLY);
    w_sel         = (w_second_half && (w_mode_eff != MODE_BYPASS)) ? SEL_CROSS : SEL_STRAIGHT;
    // Once the phase has reached DELAY since priming restarted, the post-delay
    // holds samples of this stream and every later output is valid.
    w_out_vld     = w_primed_eff | w_second_half;
    w_out_sof     = (r_sof_pend | w_sof) & (w_cnt_eff == DLY);
  end

  mdc_delay_line #(
    .WIDTH (WIDTH),
    .DELAY (DELAY)
  ) u_pre_delay (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (in_valid),
    .i_re  (inUI_re),
    .i_im  (inUI_im),
    .o_re  (w_ud_re),
    .o_im  (w_ud_im)
  );

  always_comb begin
    w_x_re = w_ud_re;
    w_x_im = w_ud_im;
    w_y_re = inLI_re;
    w_y_im = inLI_im;
    if (w_sel == SEL_CROSS) begin
      w_x_re = inLI_re;
      w_x_im = inLI_im;
      w_y_re = w_ud_re;
      w_y_im = w_ud_im;
    end
  end

  mdc_delay_line #(
    .WIDTH (WIDTH),
    .DELAY (DELAY)
  ) u_post_delay (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (in_valid),
    .i_re  (w_y_re),
    .i_im  (w_y_im),
    .o_re  (w_ly_re),
    .o_im  (w_ly_im)
  );

  // ---- stage p0 -> p1: output registers and phase/priming state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_primed    <= 1'b0;
      r_mode_q    <= MODE_SWITCH;
      r_sof_pend  <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_sof_p1    <= 1'b0;
      r_err_p1    <= 1'b0;
      r_up_re_p1  <= '0;
      r_up_im_p1  <= '0;
      r_low_re_p1 <= '0;
      r_low_im_p1 <= '0;
    end else begin
      r_vld_p1 <= in_valid & w_out_vld;
      r_sof_p1 <= in_valid & w_out_sof;
      r_err_p1 <= w_misalign;
      if (in_valid) begin
        // 2*DELAY is a power of two, so the counter wraps naturally.
        r_cnt       <= w_cnt_eff + CW'(1);
        r_primed    <= w_out_vld;
        r_mode_q    <= w_mode_eff;
        r_sof_pend  <= w_out_sof ? 1'b0 : (r_sof_pend | w_sof);
        r_up_re_p1  <= w_x_re;
        r_up_im_p1  <= w_x_im;
        r_low_re_p1 <= w_ly_re;
        r_low_im_p1 <= w_ly_im;
      end
    end
  end

  assign out_valid    = r_vld_p1;
  assign out_sof      = r_sof_p1;
  assign misalign_err = r_err_p1;
  assign Up_out_re    = r_up_re_p1;
  assign Up_out_im    = r_up_im_p1;
  assign Low_out_re   = r_low_re_p1;
  assign Low_out_im   = r_low_im_p1;

endmodule

// File: tb/tb_mdc_delay_commutator.sv
// -----------------------------------------------------------------------------
// tb_mdc_delay_commutator
//  Three instances (DELAY = 2, 4, 1) share one input stream. A history-based
//  model derives every output from the sample history; one process compares
//  all instance outputs with it on every clock, and literal expectations pin
//  the model on the directed scenarios.
// -----------------------------------------------------------------------------
module tb_mdc_delay_commutator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_sof = 1'b0;
  logic              mode = 1'b0;
  logic signed [8:0] inUI_re = '0, inUI_im = '0, inLI_re = '0, inLI_im = '0;

  logic              o_vld [3];
  logic              o_sof [3];
  logic              o_err [3];
  logic signed [8:0] o_up_re [3];
  logic signed [8:0] o_up_im [3];
  logic signed [8:0] o_low_re [3];
  logic signed [8:0] o_low_im [3];

  mdc_delay_commutator #(.WIDTH(9), .DELAY(2)) dut_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .mode(mode),
    .inUI_re(inUI_re), .inUI_im(inUI_im), .inLI_re(inLI_re), .inLI_im(inLI_im),
    .out_valid(o_vld[0]), .out_sof(o_sof[0]),
    .Up_out_re(o_up_re[0]), .Up_out_im(o_up_im[0]),
    .Low_out_re(o_low_re[0]), .Low_out_im(o_low_im[0]), .misalign_err(o_err[0]));

  mdc_delay_commutator #(.WIDTH(9), .DELAY(4)) dut_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .mode(mode),
    .inUI_re(inUI_re), .inUI_im(inUI_im), .inLI_re(inLI_re), .inLI_im(inLI_im),
    .out_valid(o_vld[1]), .out_sof(o_sof[1]),
    .Up_out_re(o_up_re[1]), .Up_out_im(o_up_im[1]),
    .Low_out_re(o_low_re[1]), .Low_out_im(o_low_im[1]), .misalign_err(o_err[1]));

  mdc_delay_commutator #(.WIDTH(9), .DELAY(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .mode(mode),
    .inUI_re(inUI_re), .inUI_im(inUI_im), .inLI_re(inLI_re), .inLI_im(inLI_im),
    .out_valid(o_vld[2]), .out_sof(o_sof[2]),
    .Up_out_re(o_up_re[2]), .Up_out_im(o_up_im[2]),
    .Low_out_re(o_low_re[2]), .Low_out_im(o_low_im[2]), .misalign_err(o_err[2]));

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Model state
  int          dl [3] = '{2, 4, 1};
  int          mk [3];        // valid samples since reset (delay-line time)
  int          mn [3];        // index since last sof
  int          msp [3];       // index since priming restarted
  bit          mq [3];        // latched mode
  bit          mhs [3];       // a sof has been seen since reset
  int          nerr [3];
  int          nsof [3];
  logic [17:0] hu [3][4096];  // upper-lane input history
  logic [17:0] hy [3][4096];  // switch lower output history
  logic [17:0] ex_up [3];
  logic [17:0] ex_low [3];
  bit          ex_vld [3];
  bit          ex_sof [3];
  bit          ex_err [3];
  logic [36:0] pq0 [$];
  logic [36:0] pq1 [$];
  logic [36:0] pq2 [$];

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic model_step();
    logic [17:0] u, l, ud, x, y, lo;
    bit sel;
    for (int i = 0; i < 3; i++) begin
      ex_vld[i] = 1'b0;
      ex_sof[i] = 1'b0;
      ex_err[i] = 1'b0;
      if (rst) begin
        mk[i] = 0; mn[i] = 0; msp[i] = 0; mq[i] = 1'b0; mhs[i] = 1'b0;
        nerr[i] = 0; nsof[i] = 0; ex_up[i] = '0; ex_low[i] = '0;
      end else if (in_valid) begin
        u = {inUI_re, inUI_im};
        l = {inLI_re, inLI_im};
        if (in_sof) begin
          if ((mn[i] % (2 * dl[i])) != 0) begin
            ex_err[i] = 1'b1;
            nerr[i]++;
            msp[i] = 0;
          end
          mn[i]  = 0;
          mhs[i] = 1'b1;
          mq[i]  = mode;
        end
        sel = ((mn[i] % (2 * dl[i])) >= dl[i]) && !mq[i];
        ud  = (mk[i] >= dl[i]) ? hu[i][mk[i] - dl[i]] : 18'd0;
        hu[i][mk[i]] = u;
        x = sel ? l : ud;
        y = sel ? ud : l;
        hy[i][mk[i]] = y;
        lo = (mk[i] >= dl[i]) ? hy[i][mk[i] - dl[i]] : 18'd0;
        ex_up[i]  = x;
        ex_low[i] = lo;
        ex_vld[i] = (msp[i] >= dl[i]);
        ex_sof[i] = mhs[i] && (mn[i] == dl[i]);
        if (ex_sof[i]) nsof[i]++;
        if (ex_vld[i]) begin
          case (i)
            0:       pq0.push_back({ex_sof[i], x, lo});
            1:       pq1.push_back({ex_sof[i], x, lo});
            default: pq2.push_back({ex_sof[i], x, lo});
          endcase
        end
        mn[i]++; msp[i]++; mk[i]++;
      end
    end
    if (rst) begin
      pq0.delete(); pq1.delete(); pq2.delete();
    end
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge.
  task automatic cycle(input bit r, input bit v, input bit s, input bit md,
                       input int ur, input int lr);
    @(negedge clk);
    rst = r; in_valid = v; in_sof = s; mode = md;
    inUI_re = 9'(ur); inUI_im = 9'(-ur);
    inLI_re = 9'(lr); inLI_im = 9'(-lr);
    @(posedge clk);
    model_step();
  endtask

  task automatic smp(input bit s, input bit md, input int ur, input int lr);
    cycle(1'b0, 1'b1, s, md, ur, lr);
  endtask

  // Idle cycle with random junk on every qualified input.
  task automatic idle();
    cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_up", i),  36'({o_up_re[i], o_up_im[i]}), 36'(0));
      chk($sformatf("rst%0d_low", i), 36'({o_low_re[i], o_low_im[i]}), 36'(0));
      chk($sformatf("rst%0d_vld", i), 36'(o_vld[i]), 36'(0));
    end
  endtask

  task automatic pin(input string nm, input int inst, input int idx,
                     input int upr, input int lor);
    logic [36:0] e;
    logic [8:0]  a, b;
    e = '0;
    if (inst == 0 && idx < pq0.size()) e = pq0[idx];
    if (inst == 1 && idx < pq1.size()) e = pq1[idx];
    if (inst == 2 && idx < pq2.size()) e = pq2[idx];
    a = 9'(upr);
    b = 9'(lor);
    chk({nm, "_up"},  36'(e[35:27]), 36'(a));
    chk({nm, "_low"}, 36'(e[17:9]),  36'(b));
  endtask

  // Compare process: every DUT output against the model on every clock.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("i%0d_up", i),  36'({o_up_re[i], o_up_im[i]}), 36'(ex_up[i]));
        chk($sformatf("i%0d_low", i), 36'({o_low_re[i], o_low_im[i]}), 36'(ex_low[i]));
        chk($sformatf("i%0d_vld", i), 36'(o_vld[i]), 36'(ex_vld[i]));
        chk($sformatf("i%0d_sof", i), 36'(o_sof[i]), 36'(ex_sof[i]));
        chk($sformatf("i%0d_err", i), 36'(o_err[i]), 36'(ex_err[i]));
      end
    end
  end

  int t1u [6] = '{52, 53, 12, 13, 56, 57};
  int t1l [6] = '{50, 51, 10, 11, 54, 55};

  initial begin
    do_reset();
    chk_en = 1'b1;

    // Switch mode, DELAY=2 reference frame
    for (int n = 0; n < 8; n++) smp(n == 0, 1'b0, 10 + n, 50 + n);
    repeat (3) idle();
    chk("t1_count", 36'(pq0.size()), 36'(6));
    chk("t1_sof", 36'(pq0.size() > 0 ? pq0[0][36] : 1'b0), 36'(1));
    for (int j = 0; j < 6; j++) pin($sformatf("t1_%0d", j), 0, j, t1u[j], t1l[j]);

    // Bypass mode
    do_reset();
    for (int n = 0; n < 8; n++) smp(n == 0, 1'b1, 10 + n, 50 + n);
    repeat (3) idle();
    chk("t2_count", 36'(pq0.size()), 36'(6));
    for (int j = 0; j < 6; j++) pin($sformatf("t2_%0d", j), 0, j, 10 + j, 50 + j);

    // Switch mode with random valid gaps
    do_reset();
    for (int n = 0; n < 8; n++) begin
      int g;
      smp(n == 0, 1'b0, 10 + n, 50 + n);
      g = int'($urandom_range(0, 2));
      repeat (g) idle();
    end
    repeat (3) idle();
    chk("t3_count", 36'(pq0.size()), 36'(6));
    for (int j = 0; j < 6; j++) pin($sformatf("t3_%0d", j), 0, j, t1u[j], t1l[j]);

    // Misaligned sof at n=3
    do_reset();
    for (int n = 0; n < 3; n++) smp(n == 0, 1'b0, 10 + n, 50 + n);
    for (int n = 0; n < 8; n++) smp(n == 0, 1'b0, 30 + n, 70 + n);
    repeat (3) idle();
    chk("t4_err", 36'(nerr[1]), 36'(1));
    chk("t4_count", 36'(pq1.size()), 36'(4));
    pin("t4_first", 1, 0, 74, 70);

    // Reset in the middle of a frame
    do_reset();
    for (int n = 0; n < 6; n++) smp(n == 0, 1'b0, 10 + n, 50 + n);
    do_reset();
    for (int n = 0; n < 8; n++) smp(n == 0, 1'b0, 30 + n, 90 + n);
    repeat (3) idle();
    pin("t5_d2", 0, 0, 92, 90);
    pin("t5_d4", 1, 0, 94, 90);
    chk("t5_count", 36'(pq1.size()), 36'(4));

    // DELAY=1 back-to-back frames of 2, mode changes only at frame boundaries
    do_reset();
    for (int f = 0; f < 8; f++) begin
      for (int s = 0; s < 2; s++) begin
        int  k;
        bit  m;
        k = 2 * f + s;
        m = (f >= 4);
        if (k == 7) m = 1'b1;
        if (k == 9) m = 1'b0;
        smp(s == 0, m, 10 + k, 50 + k);
      end
    end
    repeat (3) idle();
    chk("t6_count", 36'(pq2.size()), 36'(15));
    chk("t6_sofs", 36'(nsof[2]), 36'(8));
    pin("t6_0", 2, 0, 51, 50);
    pin("t6_1", 2, 1, 11, 10);
    pin("t6_6", 2, 6, 57, 56);
    pin("t6_7", 2, 7, 17, 16);
    pin("t6_8", 2, 8, 18, 58);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
